// File: rtl/adder_traffic_gen.sv
// Packet/flit operand stimulus generator (thermometer, alternate, LFSR) for datapath energy runs.
// Optional toggle counter is built when ADDER_TRAFFIC_TOGGLE_CNT_EN is defined.
module adder_traffic_gen #(
    parameter int unsigned    N         = 25,
    parameter int unsigned    STEP_BITS = 18,
    parameter logic [2*N-1:0] LFSR_POLY = (2*N)'(3),
    parameter logic [2*N-1:0] LFSR_SEED = (2*N)'(1),
    parameter int unsigned    CW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] cfg_payload,
    input  logic [CW-1:0] cfg_gap,
    input  logic [CW-1:0] cfg_packets,
    input  logic [1:0]    cfg_mode,
    output logic          flit_valid,
    input  logic          flit_ready,
    output logic          flit_head,
    output logic          flit_tail,
    output logic [N-1:0]  operand_a,
    output logic [N-1:0]  operand_b,
    output logic          busy,
    output logic          done,
    output logic [31:0]   toggle_cnt
);

    localparam int unsigned W     = 2 * N;
    localparam int unsigned CBITS = $clog2(2 * W + 1);
    localparam int unsigned PBITS = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

    state_t             state_q;
    logic [CW-1:0]      payload_q, gap_q, packets_q;
    logic [1:0]         mode_q;
    logic [CW-1:0]      flit_idx_q, pkt_idx_q, gap_cnt_q;
    logic [CBITS-1:0]   therm_q;
    logic               alt_q;
    logic [W-1:0]       lfsr_q;
    logic [W-1:0]       word_q;
    logic               valid_q, head_q, tail_q, busy_q, done_q;

    function automatic logic [CBITS-1:0] therm_step(input logic [CBITS-1:0] c);
        logic [CBITS-1:0] s;
        s = c + CBITS'(STEP_BITS);
        if (s > CBITS'(W)) s = s - CBITS'(W + 1);
        return s;
    endfunction

    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_POLY : '0);
    endfunction

    function automatic logic [W-1:0] pattern(input logic [1:0] mode, input logic [CBITS-1:0] c,
                                             input logic alt, input logic [W-1:0] l);
        case (mode)
            2'd1:    pattern = {W{alt}};
            2'd2:    pattern = l;
            default: pattern = ~({W{1'b1}} << c);
        endcase
    endfunction

    logic [CBITS-1:0] therm_adv_c;
    logic [W-1:0]     lfsr_adv_c, word_adv_c, word_first_c;
    logic             last_pkt_c, gap_end_c, adv_c;
    logic [CW-1:0]    adv_idx_c;

    // Next-word generation and the decision to present a new flit this edge
    always_comb begin
        therm_adv_c  = therm_step(therm_q);
        lfsr_adv_c   = lfsr_step(lfsr_q);
        word_adv_c   = pattern(mode_q, therm_adv_c, ~alt_q, lfsr_adv_c);
        word_first_c = pattern(cfg_mode, therm_step(CBITS'(0)), 1'b1, lfsr_step(LFSR_SEED));
        last_pkt_c   = (pkt_idx_q == packets_q - CW'(1));
        gap_end_c    = (gap_cnt_q == gap_q - CW'(1));
        adv_c        = 1'b0;
        adv_idx_c    = '0;
        case (state_q)
            SEND: begin
                if (flit_ready) begin
                    if (!tail_q) begin
                        adv_c     = 1'b1;
                        adv_idx_c = flit_idx_q + CW'(1);
                    end else if (!last_pkt_c && gap_q == '0) begin
                        adv_c = 1'b1;
                    end
                end
            end
            GAP:     adv_c = gap_end_c;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            payload_q  <= '0;
            gap_q      <= '0;
            packets_q  <= '0;
            mode_q     <= '0;
            flit_idx_q <= '0;
            pkt_idx_q  <= '0;
            gap_cnt_q  <= '0;
            therm_q    <= '0;
            alt_q      <= 1'b0;
            lfsr_q     <= LFSR_SEED;
            word_q     <= '0;
            valid_q    <= 1'b0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        payload_q  <= cfg_payload;
                        gap_q      <= cfg_gap;
                        packets_q  <= cfg_packets;
                        mode_q     <= cfg_mode;
                        flit_idx_q <= '0;
                        pkt_idx_q  <= '0;
                        gap_cnt_q  <= '0;
                        busy_q     <= 1'b1;
                        if (cfg_payload == '0 || cfg_packets == '0) begin
                            state_q <= FIN;
                            therm_q <= '0;
                            alt_q   <= 1'b0;
                            lfsr_q  <= LFSR_SEED;
                        end else begin
                            state_q <= SEND;
                            therm_q <= therm_step(CBITS'(0));
                            alt_q   <= 1'b1;
                            lfsr_q  <= lfsr_step(LFSR_SEED);
                            word_q  <= word_first_c;
                            valid_q <= 1'b1;
                            head_q  <= 1'b1;
                            tail_q  <= (cfg_payload == CW'(1));
                        end
                    end
                end
                SEND: begin
                    if (flit_ready && tail_q) begin
                        if (last_pkt_c) begin
                            state_q <= FIN;
                            valid_q <= 1'b0;
                            head_q  <= 1'b0;
                            tail_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            pkt_idx_q <= pkt_idx_q + CW'(1);
                            if (gap_q != '0) begin
                                state_q   <= GAP;
                                gap_cnt_q <= '0;
                                valid_q   <= 1'b0;
                                head_q    <= 1'b0;
                                tail_q    <= 1'b0;
                            end
                        end
                    end
                end
                GAP: begin
                    if (gap_end_c) state_q <= SEND;
                    else           gap_cnt_q <= gap_cnt_q + CW'(1);
                end
                FIN: begin
                    // An empty run enters FIN without done, so it spends one extra cycle here
                    if (done_q) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end else begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (adv_c) begin
                therm_q    <= therm_adv_c;
                alt_q      <= ~alt_q;
                lfsr_q     <= lfsr_adv_c;
                word_q     <= word_adv_c;
                valid_q    <= 1'b1;
                head_q     <= (adv_idx_c == '0);
                tail_q     <= (adv_idx_c == payload_q - CW'(1));
                flit_idx_q <= adv_idx_c;
            end
        end
    end

    assign flit_valid = valid_q;
    assign flit_head  = head_q;
    assign flit_tail  = tail_q;
    assign operand_a  = word_q[N-1:0];
    assign operand_b  = word_q[W-1:N];
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef ADDER_TRAFFIC_TOGGLE_CNT_EN
    logic [W-1:0]     prev_q;
    logic [31:0]      toggle_q;
    logic [PBITS-1:0] pop_c;
    logic [W-1:0]     diff_c;
    logic [32:0]      sum_c;

    // Hamming distance between the flit being transferred and the previously transferred word
    always_comb begin
        diff_c = word_q ^ prev_q;
        pop_c  = '0;
        for (int i = 0; i < W; i++) pop_c = pop_c + PBITS'(diff_c[i]);
        sum_c  = {1'b0, toggle_q} + 33'(pop_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q   <= '0;
            toggle_q <= '0;
        end else if (state_q == IDLE && start) begin
            toggle_q <= '0;
        end else if (valid_q && flit_ready) begin
            prev_q   <= word_q;
            toggle_q <= sum_c[32] ? 32'hFFFF_FFFF : sum_c[31:0];
        end
    end

    assign toggle_cnt = toggle_q;
`else
    assign toggle_cnt = '0;
`endif

endmodule

// File: tb/tb_adder_traffic_gen.sv
// Directed bench for adder_traffic_gen: reset, patterns, cadence, stalls, empty runs, mid-run reset.
module tb_adder_traffic_gen;

    localparam int N  = 25;
    localparam int W  = 50;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst, start, flit_ready;
    logic [CW-1:0] cfg_payload, cfg_gap, cfg_packets;
    logic [1:0]    cfg_mode;
    logic          flit_valid, flit_head, flit_tail, busy, done;
    logic [N-1:0]  operand_a, operand_b;
    logic [31:0]   toggle_cnt;
    logic [W-1:0]  word;

    int tests = 0;
    int fails = 0;

    adder_traffic_gen dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_payload(cfg_payload), .cfg_gap(cfg_gap), .cfg_packets(cfg_packets), .cfg_mode(cfg_mode),
        .flit_valid(flit_valid), .flit_ready(flit_ready), .flit_head(flit_head), .flit_tail(flit_tail),
        .operand_a(operand_a), .operand_b(operand_b), .busy(busy), .done(done), .toggle_cnt(toggle_cnt)
    );

    assign word = {operand_b, operand_a};

    always #5 clk = ~clk;

    function automatic logic [W-1:0] therm(input int c);
        logic [W-1:0] m;
        m = '0;
        for (int i = 0; i < c; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic int c_next(input int c);
        int s;
        s = c + 18;
        if (s > 50) s = s - 51;
        return s;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int payload, input int gap, input int packets, input int mode);
        cfg_payload = CW'(payload);
        cfg_gap     = CW'(gap);
        cfg_packets = CW'(packets);
        cfg_mode    = 2'(mode);
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; flit_ready = 1'b1;
        cfg_payload = '0; cfg_gap = '0; cfg_packets = '0; cfg_mode = '0;
        tick(); tick();
        tests++; if (flit_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", flit_valid); end
        tests++; if (flit_head !== 1'b0 || flit_tail !== 1'b0) begin fails++; $display("FAIL reset_head_tail: got %b%b want 00", flit_head, flit_tail); end
        tests++; if (word !== '0) begin fails++; $display("FAIL reset_operands: got %h want 0", word); end
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
        tests++; if (toggle_cnt !== 32'd0) begin fails++; $display("FAIL reset_toggle: got %0d want 0", toggle_cnt); end
        rst = 1'b0;
        tick();
        tests++; if (flit_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL reset_idle: valid %b busy %b want 0 0", flit_valid, busy); end
    endtask

    task automatic test_thermometer;
        int cs [6];
        cs = '{18, 36, 3, 21, 39, 6};
        pulse_start(6, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (flit_valid !== 1'b1 || busy !== 1'b1 || word !== therm(cs[i]) ||
                flit_head !== (i == 0) || flit_tail !== (i == 5)) begin
                fails++;
                $display("FAIL therm_flit%0d: valid %b busy %b head %b tail %b word %h want word %h",
                         i, flit_valid, busy, flit_head, flit_tail, word, therm(cs[i]));
            end
            if (i == 2) begin
                tests++;
                if (operand_a !== 25'h7 || operand_b !== 25'h0) begin
                    fails++; $display("FAIL therm_third: a %h b %h want a 7 b 0", operand_a, operand_b);
                end
            end
            tick();
        end
        tests++; if (done !== 1'b1 || flit_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL therm_done: done %b valid %b busy %b want 1 0 0", done, flit_valid, busy); end
        tests++; if (word !== therm(6)) begin fails++; $display("FAIL therm_hold: got %h want %h", word, therm(6)); end
        tick();
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL therm_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_cadence;
        int c, bad, wbad, heads, tails;
        c = 0; bad = 0; wbad = 0; heads = 0; tails = 0;
        pulse_start(20, 7, 10, 0);
        for (int p = 0; p < 10; p++) begin
            for (int f = 0; f < 20; f++) begin
                c = c_next(c);
                if (flit_valid !== 1'b1) bad++;
                if (flit_head !== (f == 0) || flit_tail !== (f == 19)) bad++;
                if (word !== therm(c)) wbad++;
                heads += int'(flit_head);
                tails += int'(flit_tail);
                if (p == 3 && f == 5) start = 1'b1;
                tick();
                start = 1'b0;
            end
            if (p < 9) begin
                for (int g = 0; g < 7; g++) begin
                    if (flit_valid !== 1'b0) bad++;
                    if (word !== therm(c)) wbad++;
                    tick();
                end
            end
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL cadence: %0d slot errors want 0", bad); end
        tests++; if (wbad !== 0) begin fails++; $display("FAIL cadence_words: %0d word errors want 0", wbad); end
        tests++; if (heads !== 10 || tails !== 10) begin fails++; $display("FAIL cadence_head_tail: heads %0d tails %0d want 10 10", heads, tails); end
        tests++; if (done !== 1'b1 || flit_valid !== 1'b0) begin fails++; $display("FAIL cadence_done: done %b valid %b want 1 0", done, flit_valid); end
        tick();
        tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL cadence_idle: done %b busy %b want 0 0", done, busy); end
    endtask

    task automatic test_stall;
        int c, nx, heads, tails, stallbad, seqbad;
        logic prev_stall, seen_done, ph, pt;
        logic [W-1:0] pw;
        c = 0; nx = 0; heads = 0; tails = 0; stallbad = 0; seqbad = 0;
        prev_stall = 1'b0; seen_done = 1'b0; ph = 1'b0; pt = 1'b0; pw = '0;
        pulse_start(5, 2, 2, 0);
        for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
            if (prev_stall && (flit_valid !== 1'b1 || word !== pw || flit_head !== ph || flit_tail !== pt))
                stallbad++;
            if (done === 1'b1) seen_done = 1'b1;
            flit_ready = 1'($urandom_range(0, 1));
            if (flit_valid && flit_ready) begin
                c = c_next(c);
                if (word !== therm(c)) seqbad++;
                nx++;
                heads += int'(flit_head);
                tails += int'(flit_tail);
            end
            prev_stall = flit_valid && !flit_ready;
            pw = word; ph = flit_head; pt = flit_tail;
            if (!seen_done) tick();
        end
        flit_ready = 1'b1;
        tests++; if (seen_done !== 1'b1) begin fails++; $display("FAIL stall_timeout: done %b want 1", seen_done); end
        tests++; if (stallbad !== 0) begin fails++; $display("FAIL stall_hold: %0d unstable cycles want 0", stallbad); end
        tests++; if (seqbad !== 0 || nx !== 10) begin fails++; $display("FAIL stall_seq: %0d word errors %0d transfers want 0 10", seqbad, nx); end
        tests++; if (heads !== 2 || tails !== 2) begin fails++; $display("FAIL stall_head_tail: heads %0d tails %0d want 2 2", heads, tails); end
        tick();
    endtask

    task automatic test_single_and_empty;
        int c;
        c = 0;
        pulse_start(1, 0, 3, 0);
        for (int i = 0; i < 3; i++) begin
            c = c_next(c);
            tests++;
            if (flit_valid !== 1'b1 || flit_head !== 1'b1 || flit_tail !== 1'b1 || word !== therm(c)) begin
                fails++; $display("FAIL single_flit%0d: valid %b head %b tail %b word %h want 1 1 1 %h",
                                  i, flit_valid, flit_head, flit_tail, word, therm(c));
            end
            tick();
        end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL single_done: got %b want 1", done); end
        tick();
        pulse_start(0, 5, 3, 0);
        tests++; if (flit_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL empty_c1: valid %b done %b busy %b want 0 0 1", flit_valid, done, busy); end
        tick();
        tests++; if (done !== 1'b1 || flit_valid !== 1'b0) begin fails++; $display("FAIL empty_c2: done %b valid %b want 1 0", done, flit_valid); end
        tick();
        tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL empty_end: done %b busy %b want 0 0", done, busy); end
        pulse_start(4, 0, 0, 0);
        tick();
        tests++; if (done !== 1'b1 || flit_valid !== 1'b0) begin fails++; $display("FAIL zero_packets: done %b valid %b want 1 0", done, flit_valid); end
        tick();
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] exp_l [8];
        exp_l = '{50'h3, 50'h2, 50'h1, 50'h3, 50'h2, 50'h1, 50'h3, 50'h2};
        pulse_start(8, 0, 1, 2);
        tests++; if (word !== 50'h3 || flit_head !== 1'b1) begin fails++; $display("FAIL lfsr_first: word %h head %b want 3 1", word, flit_head); end
        tick();
        tests++; if (word !== 50'h2) begin fails++; $display("FAIL lfsr_second: word %h want 2", word); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (flit_valid !== 1'b0 || flit_head !== 1'b0 || flit_tail !== 1'b0 || word !== '0 ||
            busy !== 1'b0 || done !== 1'b0 || toggle_cnt !== 32'd0) begin
            fails++; $display("FAIL midrst_clear: valid %b head %b tail %b word %h busy %b done %b tog %0d want all 0",
                              flit_valid, flit_head, flit_tail, word, busy, done, toggle_cnt);
        end
        tick();
        tests++; if (flit_valid !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL midrst_idle: valid %b done %b want 0 0", flit_valid, done); end
        pulse_start(8, 0, 1, 2);
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (flit_valid !== 1'b1 || word !== exp_l[i]) begin
                fails++; $display("FAIL rerun_flit%0d: valid %b word %h want 1 %h", i, flit_valid, word, exp_l[i]);
            end
            tick();
        end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL rerun_done: got %b want 1", done); end
        tick();
    endtask

    task automatic test_toggle;
        logic [W-1:0] exp_w [4];
        logic [31:0]  exp_t;
        exp_w = '{{W{1'b1}}, {W{1'b0}}, {W{1'b1}}, {W{1'b0}}};
`ifdef ADDER_TRAFFIC_TOGGLE_CNT_EN
        exp_t = 32'd200;
`else
        exp_t = 32'd0;
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        pulse_start(4, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (flit_valid !== 1'b1 || word !== exp_w[i]) begin
                fails++; $display("FAIL alt_flit%0d: valid %b word %h want 1 %h", i, flit_valid, word, exp_w[i]);
            end
            tick();
        end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL alt_done: got %b want 1", done); end
        tests++; if (toggle_cnt !== exp_t) begin fails++; $display("FAIL toggle_cnt: got %0d want %0d", toggle_cnt, exp_t); end
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; flit_ready = 1'b1;
        cfg_payload = '0; cfg_gap = '0; cfg_packets = '0; cfg_mode = '0;
        test_reset();
        test_thermometer();
        test_cadence();
        test_stall();
        test_single_and_empty();
        test_reset_mid();
        test_toggle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
